// File: rtl/spi_video_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_video_host_tx : packs memory-write requests into 32-bit words and    |
// | shifts them MSB-first to the video-memory SPI port.   Revision: 1.0      |
// +--------------------------------------------------------------------------+
module spi_video_host_tx #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_ram_select,
  input  logic [14:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        spi_sck,
  output logic        spi_sda,
  input  logic        spi_ready,
  output logic        busy,
  output logic [15:0] words_sent
);

  localparam int                 c_cnt_w      = $clog2(WORD_BITS);
  localparam logic [c_cnt_w-1:0] c_bit_last   = c_cnt_w'(WORD_BITS - 1);
  localparam logic [7:0]         c_phase_last = 8'(CLK_DIV - 1);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_wait_rdy = 3'd1;
  localparam logic [2:0] c_low      = 3'd2;
  localparam logic [2:0] c_high     = 3'd3;
  localparam logic [2:0] c_gap      = 3'd4;

  generate
    if (WORD_BITS != 32) begin : g_word_bits_check
      $error("spi_video_host_tx: WORD_BITS must be 32");
    end
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_clk_div_check
      $error("spi_video_host_tx: CLK_DIV must be in 1..255");
    end
  endgenerate

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic                 r_rdy_meta;
  logic                 r_rdy_s;
  logic [7:0]           r_phase;
  logic [c_cnt_w-1:0]   r_bit_cnt;
  logic [WORD_BITS-1:0] r_shift;
  logic [15:0]          r_words_sent;
  logic                 r_sck;
  logic                 r_sda;
  logic                 r_wr_ready;
  logic                 r_busy;
  logic                 w_phase_done;
  logic                 w_accept;
  logic                 w_timed;
  logic                 w_sck_d;
  logic                 w_sda_d;
  logic                 w_wr_ready_d;
  logic                 w_busy_d;

  assign w_phase_done = (r_phase == c_phase_last);
  assign w_accept     = wr_valid && r_wr_ready && (r_state == c_idle);
  assign w_timed      = (r_state == c_low) || (r_state == c_high) || (r_state == c_gap);

  // spi_ready comes from the sink's clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_meta <= 1'b0;
      r_rdy_s    <= 1'b0;
    end else begin
      r_rdy_meta <= spi_ready;
      r_rdy_s    <= r_rdy_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:     if (w_accept) w_state_next = c_wait_rdy;
      c_wait_rdy: if (r_rdy_s) w_state_next = c_low;
      c_low:      if (w_phase_done) w_state_next = c_high;
      c_high: begin
        if (w_phase_done) begin
          w_state_next = (r_bit_cnt == '0) ? c_gap : c_low;
        end
      end
      c_gap:      if (w_phase_done) w_state_next = c_idle;
      default:    w_state_next = c_idle;
    endcase
  end

  // Serial pins follow the current state one cycle later; the handshake
  // flops follow the next state so wr_ready lines up with IDLE exactly.
  always_comb begin
    w_sck_d      = 1'b0;
    w_sda_d      = 1'b0;
    w_wr_ready_d = (w_state_next == c_idle);
    w_busy_d     = (w_state_next != c_idle);
    case (r_state)
      c_low:   w_sda_d = r_shift[WORD_BITS-1];
      c_high: begin
        w_sck_d = 1'b1;
        w_sda_d = r_sda;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck      <= 1'b0;
      r_sda      <= 1'b0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sck      <= w_sck_d;
      r_sda      <= w_sda_d;
      r_wr_ready <= w_wr_ready_d;
      r_busy     <= w_busy_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase      <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_words_sent <= '0;
    end else begin
      r_phase <= (w_timed && !w_phase_done) ? r_phase + 8'd1 : 8'd0;
      if (w_accept) begin
        r_shift   <= {wr_ram_select, wr_addr, wr_data};
        r_bit_cnt <= c_bit_last;
      end else if ((r_state == c_high) && w_phase_done && (r_bit_cnt != '0)) begin
        r_shift   <= {r_shift[WORD_BITS-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
      if ((r_state == c_gap) && w_phase_done) begin
        r_words_sent <= r_words_sent + 16'd1;
      end
    end
  end

  assign spi_sck    = r_sck;
  assign spi_sda    = r_sda;
  assign wr_ready   = r_wr_ready;
  assign busy       = r_busy;
  assign words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_spi_video_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_video_host_tx : scoreboard bench for spi_video_host_tx at         |
// | CLK_DIV=2 and CLK_DIV=1.                              Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_spi_video_host_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0, wr_ram_select = 1'b0, spi_ready = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready, spi_sck, spi_sda, busy;
  logic [15:0] words_sent;

  logic        f_valid = 1'b0, f_sel = 1'b0, f_spi_ready = 1'b1;
  logic [14:0] f_addr = '0;
  logic [15:0] f_data = '0;
  logic        f_ready, f_sck, f_sda, f_busy;
  logic [15:0] f_words;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc;

  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] f_exp_q[$];
  logic [31:0] f_rx_q[$];

  // slow-instance monitor state
  logic [31:0] m_sh = '0;
  int m_bits = 0, m_prev = 0, m_low_run = 0, m_words = 0;
  int min_gap = 1000, rise_cnt = 0, first_rise_cyc = 0;
  // fast-instance monitor state
  logic [31:0] f_sh = '0;
  int f_bits = 0, f_prev = 0, f_prev_sda = 0, f_last_rise = 0;
  int f_period_bad = 0, f_sda_bad = 0, f_rise_cnt = 0;

  spi_video_host_tx #(.CLK_DIV(2), .WORD_BITS(32)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ram_select(wr_ram_select), .wr_addr(wr_addr), .wr_data(wr_data),
    .spi_sck(spi_sck), .spi_sda(spi_sda), .spi_ready(spi_ready),
    .busy(busy), .words_sent(words_sent)
  );

  spi_video_host_tx #(.CLK_DIV(1), .WORD_BITS(32)) dut_fast (
    .clk(clk), .reset(reset), .wr_valid(f_valid), .wr_ready(f_ready),
    .wr_ram_select(f_sel), .wr_addr(f_addr), .wr_data(f_data),
    .spi_sck(f_sck), .spi_sda(f_sda), .spi_ready(f_spi_ready),
    .busy(f_busy), .words_sent(f_words)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // slow monitor: receive words on sck rising edges
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      m_bits = 0; m_prev = 0; m_low_run = 0;
    end else begin
      if (spi_sck && m_prev == 0) begin
        rise_cnt++;
        if (m_bits == 0) begin
          first_rise_cyc = cyc;
          if (m_words > 0 && m_low_run < min_gap) min_gap = m_low_run;
        end
        m_sh = {m_sh[30:0], spi_sda};
        m_bits++;
        if (m_bits == 32) begin
          rx_q.push_back(m_sh);
          m_bits = 0;
          m_words++;
        end
      end
      if (!spi_sck) m_low_run++; else m_low_run = 0;
      m_prev = int'(spi_sck);
    end
  end

  // fast monitor: also checks sck period and sda stability at each rise
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      f_bits = 0; f_prev = 0;
    end else begin
      if (f_sck && f_prev == 0) begin
        f_rise_cnt++;
        if (f_bits > 0 && cyc - f_last_rise != 2) f_period_bad++;
        if (int'(f_sda) != f_prev_sda) f_sda_bad++;
        f_last_rise = cyc;
        f_sh = {f_sh[30:0], f_sda};
        f_bits++;
        if (f_bits == 32) begin
          f_rx_q.push_back(f_sh);
          f_bits = 0;
        end
      end
      f_prev = int'(f_sck);
      f_prev_sda = int'(f_sda);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic sel, input logic [14:0] a, input logic [15:0] d, input bit hold);
    bit ok = 1'b0;
    wr_ram_select = sel; wr_addr = a; wr_data = d; wr_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (wr_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) exp_q.push_back({sel, a, d});
    else check("accept_timeout", 32'(wr_ready), 32'd1);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold || !ok) wr_valid = 1'b0;
  endtask

  task automatic f_send(input logic sel, input logic [14:0] a, input logic [15:0] d);
    bit ok = 1'b0;
    f_sel = sel; f_addr = a; f_data = d; f_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (f_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) f_exp_q.push_back({sel, a, d});
    else check("f_accept_timeout", 32'(f_ready), 32'd1);
    @(negedge clk);
    acc_cyc = cyc;
    f_valid = 1'b0;
  endtask

  task automatic wait_ready(input bit fast, output int c);
    int n = 0;
    while (!(fast ? f_ready : wr_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
    if (n >= 3000) check("wait_ready_timeout", 32'(fast ? f_ready : wr_ready), 32'd1);
  endtask

  task automatic expect_word(input string tag, input bit fast);
    int n = 0;
    logic [31:0] got, e;
    while ((fast ? f_rx_q.size() : rx_q.size()) == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if ((fast ? f_rx_q.size() : rx_q.size()) == 0) begin
      check({tag, "_timeout"}, 32'(fast ? f_rx_q.size() : rx_q.size()), 32'd1);
    end else begin
      if (fast) begin
        got = f_rx_q.pop_front();
        e = (f_exp_q.size() > 0) ? f_exp_q.pop_front() : 'x;
      end else begin
        got = rx_q.pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      end
      check(tag, got, e);
    end
  endtask

  initial begin
    int rc, t, n, bad_sck, bad_busy, r0;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_sda", 32'(spi_sda), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words_sent", 32'(words_sent), 32'd0);
    reset = 1'b1;
    spi_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_wr_ready", 32'(wr_ready), 32'd1);

    // 1: basic word and latency
    send(1'b1, 15'h0123, 16'hBEEF, 1'b0);
    t = acc_cyc;
    wait_ready(1'b0, rc);
    check("t1_latency", 32'(rc - t), 32'd131);
    check("t1_first_rise", 32'(first_rise_cyc - t), 32'd4);
    expect_word("t1_word", 1'b0);
    check("t1_words_sent", 32'(words_sent), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // 2: flow control at word start
    spi_ready = 1'b0;
    repeat (4) @(negedge clk);
    send(1'b0, 15'h7FFF, 16'h0001, 1'b0);
    bad_sck = 0; bad_busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (spi_sck) bad_sck++;
      if (!busy) bad_busy++;
    end
    check("t2_sck_held_low", 32'(bad_sck), 32'd0);
    check("t2_busy_held", 32'(bad_busy), 32'd0);
    spi_ready = 1'b1;
    n = cyc;
    expect_word("t2_word", 1'b0);
    check("t2_first_rise", 32'(first_rise_cyc - n), 32'd6);
    wait_ready(1'b0, rc);

    // 3: back-to-back with wr_valid held
    min_gap = 1000;
    r0 = rise_cnt;
    send(1'b0, 15'h0000, 16'h0000, 1'b1);
    send(1'b0, 15'h0001, 16'hFFFF, 1'b1);
    send(1'b0, 15'h0002, 16'hA5A5, 1'b0);
    expect_word("t3_word0", 1'b0);
    expect_word("t3_word1", 1'b0);
    expect_word("t3_word2", 1'b0);
    wait_ready(1'b0, rc);
    check("t3_rise_count", 32'(rise_cnt - r0), 32'd96);
    check("t3_min_gap_ok", 32'(min_gap >= 3), 32'd1);
    check("t3_words_sent", 32'(words_sent), 32'd5);

    // 4: spi_ready drop mid-word
    send(1'b1, 15'h0055, 16'h1234, 1'b0);
    n = 0;
    while (m_bits < 11 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    spi_ready = 1'b0;
    send(1'b0, 15'h0056, 16'h4321, 1'b0);
    expect_word("t4_word_a", 1'b0);
    bad_sck = 0; bad_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (spi_sck) bad_sck++;
      if (!busy) bad_busy++;
    end
    check("t4_next_waits", 32'(bad_sck), 32'd0);
    check("t4_next_busy", 32'(bad_busy), 32'd0);
    spi_ready = 1'b1;
    expect_word("t4_word_b", 1'b0);
    wait_ready(1'b0, rc);

    // 5: asynchronous reset mid-word
    send(1'b1, 15'h7FFF, 16'hFFFF, 1'b0);
    n = 0;
    while (m_bits < 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1'b0;
    #1;
    check("t5_sck_async", 32'(spi_sck), 32'd0);
    check("t5_sda_async", 32'(spi_sda), 32'd0);
    check("t5_wr_ready_async", 32'(wr_ready), 32'd0);
    check("t5_busy_async", 32'(busy), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_wr_ready_after", 32'(wr_ready), 32'd1);
    check("t5_words_sent_cleared", 32'(words_sent), 32'd0);
    check("t5_no_partial_word", 32'(rx_q.size()), 32'd0);

    // 6: CLK_DIV=1 timing and words_sent wrap
    force dut_fast.r_words_sent = 16'hFFFE;
    #1 release dut_fast.r_words_sent;
    @(negedge clk);
    check("t6_preload", 32'(f_words), 32'h0000_FFFE);
    f_send(1'b0, 15'h1234, 16'hCAFE);
    t = acc_cyc;
    wait_ready(1'b1, rc);
    check("t6_latency", 32'(rc - t), 32'd66);
    check("t6_words_ffff", 32'(f_words), 32'h0000_FFFF);
    expect_word("t6_word0", 1'b1);
    f_send(1'b1, 15'h0F0F, 16'h8001);
    wait_ready(1'b1, rc);
    check("t6_words_wrap", 32'(f_words), 32'd0);
    expect_word("t6_word1", 1'b1);
    check("t6_sck_period", 32'(f_period_bad), 32'd0);
    check("t6_sda_stable", 32'(f_sda_bad), 32'd0);
    check("t6_rise_count", 32'(f_rise_cnt), 32'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
